// File: rtl/cnn_layer_sequencer.sv
// Walks a small layer table and hands each CNN layer's base addresses and
// config word to the accelerator, one layer at a time.
module cnn_layer_sequencer #(
   parameter int MAX_LAYERS = 8,
   parameter int TI         = 16,
   parameter int TO         = 16,
   parameter int NW         = 16,
   parameter int TIMEOUT    = 1048575
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        cfg_we,
   input  logic [3:0]  cfg_addr,
   input  logic [8:0]  cfg_wdata,
   input  logic [3:0]  num_layers,
   input  logic        start,
   input  logic        abort,
   input  logic        acc_layer_done,
   output logic [31:0] acc_base_addr,
   output logic [31:0] acc_layer_cfg,
   output logic        acc_cfg_valid,
   output logic        acc_start,
   output logic        busy,
   output logic [3:0]  layer_idx,
   output logic        done_irq,
   output logic        err
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_START, S_WAIT, S_ADVANCE, S_FINISH
   } state_t;

   localparam logic [3:0]  MAX_N    = 4'(MAX_LAYERS);
   localparam logic [19:0] WB_STEP3 = 20'(TI * TO * 9 / NW);
   localparam logic [19:0] WB_STEP1 = 20'(TO);
   localparam logic [11:0] PB_STEP  = 12'(TO);
   localparam logic [19:0] TMO_LAST = 20'(TIMEOUT - 1);

   // Handshake: acc_cfg_valid and acc_start are one-cycle strobes with no
   // back-pressure; the accelerator answers with acc_layer_done held as a
   // level, which must drop again before the next layer reaches WAIT.
   state_t      state;
   logic [8:0]  layer_table [16];
   logic [3:0]  num_latched;
   logic [19:0] weight_base;
   logic [11:0] param_base;
   logic [19:0] tmo_cnt;
   logic [19:0] nxt_wb;
   logic [11:0] nxt_pb;
   logic [3:0]  nxt_idx;
   logic        cur_last;

   function automatic logic [31:0] cfg_word(input logic [3:0] idx, input logic last,
                                            input logic [8:0] entry);
      return {16'b0, entry[8:6], entry[5:1], idx, last, entry[0], last, idx == 4'd0};
   endfunction

   assign busy = (state != S_IDLE);

   // The table survives reset so software need not reload it after a recovery.
   always_ff @(posedge HCLK) begin
      if (cfg_we && !busy && cfg_addr < MAX_N)
         layer_table[cfg_addr] <= cfg_wdata;
   end

   always_comb begin
      nxt_idx  = layer_idx + 4'd1;
      nxt_wb   = weight_base + (layer_table[layer_idx][0] ? WB_STEP3 : WB_STEP1);
      nxt_pb   = param_base + PB_STEP;
      cur_last = (layer_idx == num_latched - 4'd1);
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state         <= S_IDLE;
         num_latched   <= '0;
         weight_base   <= '0;
         param_base    <= '0;
         tmo_cnt       <= '0;
         layer_idx     <= '0;
         acc_base_addr <= '0;
         acc_layer_cfg <= '0;
         acc_cfg_valid <= 1'b0;
         acc_start     <= 1'b0;
         done_irq      <= 1'b0;
         err           <= 1'b0;
      end else if (abort && state != S_IDLE) begin
         state         <= S_IDLE;
         acc_cfg_valid <= 1'b0;
         acc_start     <= 1'b0;
         done_irq      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (num_layers == 4'd0 || num_layers > MAX_N) begin
                     err <= 1'b1;
                  end else begin
                     // Config for layer 0 is registered now so it is on the
                     // bus for the whole LOAD cycle.
                     num_latched   <= num_layers;
                     err           <= 1'b0;
                     layer_idx     <= 4'd0;
                     weight_base   <= '0;
                     param_base    <= '0;
                     acc_base_addr <= '0;
                     acc_layer_cfg <= cfg_word(4'd0, num_layers == 4'd1, layer_table[0]);
                     acc_cfg_valid <= 1'b1;
                     state         <= S_LOAD;
                  end
               end
            end
            S_LOAD: begin
               acc_cfg_valid <= 1'b0;
               acc_start     <= 1'b1;
               state         <= S_START;
            end
            S_START: begin
               acc_start <= 1'b0;
               tmo_cnt   <= '0;
               state     <= S_WAIT;
            end
            S_WAIT: begin
               if (acc_layer_done) begin
                  state <= S_ADVANCE;
               end else if (tmo_cnt == TMO_LAST) begin
                  err   <= 1'b1;
                  state <= S_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 20'd1;
               end
            end
            S_ADVANCE: begin
               weight_base <= nxt_wb;
               param_base  <= nxt_pb;
               if (cur_last) begin
                  done_irq <= 1'b1;
                  state    <= S_FINISH;
               end else begin
                  layer_idx     <= nxt_idx;
                  acc_base_addr <= {nxt_pb, nxt_wb};
                  acc_layer_cfg <= cfg_word(nxt_idx, nxt_idx == num_latched - 4'd1,
                                            layer_table[nxt_idx]);
                  acc_cfg_valid <= 1'b1;
                  state         <= S_LOAD;
               end
            end
            S_FINISH: begin
               done_irq <= 1'b0;
               state    <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Directed bench for cnn_layer_sequencer: table runs, start errors, timeout,
// abort and mid-run reset, with hand-computed addresses and config words.
module tb_cnn_layer_sequencer;

   logic        HCLK;
   logic        HRESET;
   logic        cfg_we;
   logic [3:0]  cfg_addr;
   logic [8:0]  cfg_wdata;
   logic [3:0]  num_layers;
   logic        start;
   logic        abort;
   logic        acc_layer_done;
   logic [31:0] acc_base_addr;
   logic [31:0] acc_layer_cfg;
   logic        acc_cfg_valid;
   logic        acc_start;
   logic        busy;
   logic [3:0]  layer_idx;
   logic        done_irq;
   logic        err;

   int n_checks = 0;
   int n_pass   = 0;
   int n_start;
   int n_irq;
   logic [31:0] exp_q[$];
   logic [31:0] cfg_log[$];

   localparam int DONE_DELAY = 10;

   cnn_layer_sequencer #(.TIMEOUT(50)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_wdata(cfg_wdata), .num_layers(num_layers), .start(start), .abort(abort),
      .acc_layer_done(acc_layer_done), .acc_base_addr(acc_base_addr),
      .acc_layer_cfg(acc_layer_cfg), .acc_cfg_valid(acc_cfg_valid),
      .acc_start(acc_start), .busy(busy), .layer_idx(layer_idx),
      .done_irq(done_irq), .err(err)
   );

   // clock / reset
   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish, required finish before 2ms");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, want);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_base"}, acc_base_addr, 32'h0);
      check({tag, "_cfg"}, acc_layer_cfg, 32'h0);
      check({tag, "_ctl"}, {25'b0, acc_cfg_valid, acc_start, busy, done_irq, err, 2'b0}, 32'h0);
      check({tag, "_idx"}, {28'b0, layer_idx}, 32'h0);
   endtask

   task automatic write_entry(input logic [3:0] addr, input logic [8:0] data);
      cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
      @(negedge HCLK);
      cfg_we = 1'b0;
   endtask

   task automatic push_run3();
      exp_q.push_back(32'h0000_0000);
      exp_q.push_back(32'h0100_0010);
      exp_q.push_back(32'h0200_00A0);
   endtask

   // cut_kind: 0 run to completion, 1 abort with layer_done on cut_layer,
   // 2 async reset in the WAIT of cut_layer.
   task automatic run_layers(input logic [3:0] n, input int cut_kind, input int cut_layer);
      int countdown;
      int tail;
      bit stop;
      countdown = -1; tail = -1; stop = 1'b0;
      n_start = 0; n_irq = 0; cfg_log.delete();
      num_layers = n; start = 1'b1;
      @(negedge HCLK);
      start = 1'b0;
      for (int cyc = 0; cyc < 3000 && !stop; cyc++) begin
         if (acc_cfg_valid) begin
            cfg_log.push_back(acc_layer_cfg);
            if (exp_q.size() == 0) check("extra_cfg_strobe", 32'd1, 32'd0);
            else check("base_addr", acc_base_addr, exp_q.pop_front());
         end
         if (done_irq) n_irq++;
         if (acc_start) begin
            n_start++;
            countdown = DONE_DELAY;
         end else if (countdown > 0) begin
            countdown--;
         end else if (countdown == 0) begin
            acc_layer_done = 1'b1;
            countdown = -1;
            if (cut_kind == 1 && int'(layer_idx) == cut_layer) begin
               abort = 1'b1;
               tail = 1;
            end
         end
         if (cut_kind == 2 && int'(layer_idx) == cut_layer && countdown == 5) begin
            #2 HRESET = 1'b1;
            #1 check_all_zero("rst_async");
            tail = 1;
         end
         if (cyc == 3) begin
            // table write and restart attempt while busy; both must be ignored
            cfg_we = 1'b1; cfg_addr = 4'd2; cfg_wdata = 9'h1C0;
            start = 1'b1; num_layers = 4'd1;
         end
         if (done_irq && tail < 0) tail = 3;
         @(negedge HCLK);
         acc_layer_done = 1'b0; abort = 1'b0; cfg_we = 1'b0; start = 1'b0; HRESET = 1'b0;
         if (tail > 0) begin
            tail--;
            if (tail == 0) stop = 1'b1;
         end
      end
      if (!stop) check("run_cycle_budget", 32'd0, 32'd1);
   endtask

   task automatic bad_start(input logic [3:0] n, input string tag);
      int seen;
      seen = 0;
      num_layers = n; start = 1'b1;
      @(negedge HCLK);
      start = 1'b0;
      check({tag, "_err"}, {31'b0, err}, 32'd1);
      for (int i = 0; i < 6; i++) begin
         if (busy || acc_start) seen++;
         @(negedge HCLK);
      end
      check({tag, "_no_activity"}, seen, 32'd0);
   endtask

   initial begin
      int found;
      int wait_cnt;
      int irq_cnt;
      HRESET = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; num_layers = '0;
      start = 1'b0; abort = 1'b0; acc_layer_done = 1'b0;
      @(negedge HCLK);
      check_all_zero("reset");
      HRESET = 1'b0;
      @(negedge HCLK);

      write_entry(4'd0, 9'h000);
      write_entry(4'd1, 9'h001);
      write_entry(4'd2, 9'h001);
      for (int i = 3; i < 8; i++) write_entry(4'(i), 9'h000);

      // three-layer run
      push_run3();
      run_layers(4'd3, 0, 0);
      check("run3_strobes", cfg_log.size(), 32'd3);
      if (cfg_log.size() == 3) begin
         check("run3_cfg0", cfg_log[0], 32'h0000_0001);
         check("run3_cfg1", cfg_log[1], 32'h0000_0014);
         check("run3_cfg2", cfg_log[2], 32'h0000_002E);
      end
      check("run3_starts", n_start, 32'd3);
      check("run3_irq", n_irq, 32'd1);
      check("run3_idle", {30'b0, busy, err}, 32'd0);
      check("run3_exp_left", exp_q.size(), 32'd0);

      // illegal layer counts
      bad_start(4'd0, "nl0");
      bad_start(4'd9, "nl9");

      // full-depth run; also clears err
      exp_q.push_back(32'h0000_0000); exp_q.push_back(32'h0100_0010);
      exp_q.push_back(32'h0200_00A0); exp_q.push_back(32'h0300_0130);
      exp_q.push_back(32'h0400_0140); exp_q.push_back(32'h0500_0150);
      exp_q.push_back(32'h0600_0160); exp_q.push_back(32'h0700_0170);
      run_layers(4'd8, 0, 0);
      check("run8_strobes", cfg_log.size(), 32'd8);
      if (cfg_log.size() == 8) check("run8_cfg7", cfg_log[7], 32'h0000_007A);
      check("run8_irq", n_irq, 32'd1);
      check("run8_err_cleared", {31'b0, err}, 32'd0);
      check("run8_exp_left", exp_q.size(), 32'd0);

      // timeout: no layer_done ever
      num_layers = 4'd1; start = 1'b1;
      @(negedge HCLK);
      start = 1'b0;
      found = 0;
      for (int i = 0; i < 20 && found == 0; i++) begin
         if (acc_start) found = 1;
         else @(negedge HCLK);
      end
      check("tmo_start_seen", found, 32'd1);
      wait_cnt = 0; irq_cnt = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge HCLK);
         if (done_irq) irq_cnt++;
         if (err) break;
         wait_cnt++;
      end
      check("tmo_wait_cycles", wait_cnt, 32'd50);
      check("tmo_err", {31'b0, err}, 32'd1);
      check("tmo_busy", {31'b0, busy}, 32'd0);
      check("tmo_irq", irq_cnt, 32'd0);

      // abort together with layer_done on layer 1
      exp_q.push_back(32'h0000_0000);
      exp_q.push_back(32'h0100_0010);
      run_layers(4'd3, 1, 1);
      check("abort_busy", {31'b0, busy}, 32'd0);
      check("abort_idx", {28'b0, layer_idx}, 32'd1);
      check("abort_irq", n_irq, 32'd0);
      check("abort_strobes", cfg_log.size(), 32'd2);
      exp_q.delete();
      push_run3();
      run_layers(4'd3, 0, 0);
      check("post_abort_irq", n_irq, 32'd1);
      check("post_abort_exp_left", exp_q.size(), 32'd0);

      // reset during WAIT of layer 2, then table must still be intact
      push_run3();
      run_layers(4'd3, 2, 2);
      check("rst_run_irq", n_irq, 32'd0);
      check_all_zero("rst_after");
      exp_q.delete();
      push_run3();
      run_layers(4'd3, 0, 0);
      check("post_rst_irq", n_irq, 32'd1);
      check("post_rst_exp_left", exp_q.size(), 32'd0);
      if (cfg_log.size() == 3) check("post_rst_cfg2", cfg_log[2], 32'h0000_002E);

      // single layer with non-zero shift fields
      write_entry(4'd0, 9'h167);
      exp_q.push_back(32'h0000_0000);
      run_layers(4'd1, 0, 0);
      check("one_strobes", cfg_log.size(), 32'd1);
      if (cfg_log.size() == 1) check("one_cfg", cfg_log[0], 32'h0000_B30F);
      check("one_irq", n_irq, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
